// File: rtl/rev_ctrl_pkg.sv
// Shared state and range-level encodings for the revolution-range sequencer and the range FSM.
package rev_ctrl_pkg;

    typedef enum logic [2:0] {
        IDLE,
        STEP,
        DWELL,
        HOLD,
        OFF,
        ERR
    } rev_state_t;

    localparam logic [1:0] LVL_OFF = 2'b00;
    localparam logic [1:0] LVL_1   = 2'b01;
    localparam logic [1:0] LVL_2   = 2'b10;
    localparam logic [1:0] LVL_3   = 2'b11;

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/rev_tmr.sv
// Loadable down-counter that saturates at zero; shared by the dwell, off and watchdog phases.
// Latency: load takes effect at the next edge; zero is a decode of the count register.
// Backpressure: none; it counts every cycle it is not loaded.
module rev_tmr #(
    parameter int W = 6
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         load,
    input  logic [W-1:0] load_val,
    output logic         zero
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = load_val;
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - W'(1);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign zero = (cnt_q == '0);

endmodule

// File: rtl/rev_ramp_sequencer.sv
// Ramps the range FSM one confirmed step at a time; downshifts by a forced off phase then a fresh ramp.
// Latency: N*(2+DWELL_CYCLES) cycles for an N-step ramp; a down command adds OFF_CYCLES first.
// Backpressure: cmd_ready only in IDLE/HOLD; REV_RAMP_TIMEOUT_EN adds a per-step watchdog and ERR.
module rev_ramp_sequencer
    import rev_ctrl_pkg::*;
#(
    parameter int DWELL_CYCLES   = 16,
    parameter int OFF_CYCLES     = 4,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic [1:0] cmd_level,
    input  logic [1:0] c_fb,
    input  logic       err_clr,
    output logic       rev_a,
    output logic [1:0] rev_r,
    output logic [1:0] cur_level,
    output logic       busy,
    output logic       done,
    output logic       err
);

    localparam int MAX_CYC = max3(DWELL_CYCLES, OFF_CYCLES, TIMEOUT_CYCLES);
    localparam int CW      = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;
    localparam logic [CW-1:0] DWELL_LD = CW'(DWELL_CYCLES - 1);
    localparam logic [CW-1:0] OFF_LD   = CW'(OFF_CYCLES - 1);
`ifdef REV_RAMP_TIMEOUT_EN
    localparam logic [CW-1:0] TMO_LD   = CW'(TIMEOUT_CYCLES - 1);
`endif

    rev_state_t    state_q, state_d;
    logic [1:0]    step_q, step_d;
    logic [1:0]    target_q, target_d;
    logic [1:0]    cur_level_q, cur_level_d;
    logic          done_q, done_d;
    logic          tmr_load;
    logic [CW-1:0] tmr_val;
    logic          tmr_zero;

    rev_tmr #(.W(CW)) u_tmr (
        .clk      (clk),
        .reset_n  (reset_n),
        .load     (tmr_load),
        .load_val (tmr_val),
        .zero     (tmr_zero)
    );

    always_comb begin
        state_d     = state_q;
        step_d      = step_q;
        target_d    = target_q;
        cur_level_d = cur_level_q;
        done_d      = 1'b0;
        tmr_load    = 1'b0;
        tmr_val     = '0;
        case (state_q)
            IDLE: begin
                if (cmd_valid) begin
                    if (cmd_level == LVL_OFF) begin
                        done_d = 1'b1;
                    end else begin
                        target_d = cmd_level;
                        step_d   = LVL_1;
                        state_d  = STEP;
                    end
                end
            end
            STEP: begin
                if (c_fb == step_q) begin
                    cur_level_d = step_q;
                    tmr_load    = 1'b1;
                    tmr_val     = DWELL_LD;
                    state_d     = DWELL;
                end else if (step_q != LVL_1 && c_fb == LVL_OFF) begin
                    // Above range 1 the FSM was already running, so 00 means it lost A.
                    state_d = OFF;
                end
`ifdef REV_RAMP_TIMEOUT_EN
                else if (tmr_zero) begin
                    cur_level_d = LVL_OFF;
                    state_d     = ERR;
                end
`endif
            end
            DWELL: begin
                if (c_fb == LVL_OFF) begin
                    state_d = OFF;
                end else if (tmr_zero) begin
                    if (step_q == target_q) begin
                        done_d  = 1'b1;
                        state_d = HOLD;
                    end else begin
                        step_d  = step_q + 2'd1;
                        state_d = STEP;
                    end
                end
            end
            HOLD: begin
                if (cmd_valid) begin
                    if (cmd_level > cur_level_q) begin
                        target_d = cmd_level;
                        step_d   = cur_level_q + 2'd1;
                        state_d  = STEP;
                    end else if (cmd_level == cur_level_q) begin
                        done_d = 1'b1;
                    end else begin
                        target_d = cmd_level;
                        state_d  = OFF;
                    end
                end else if (c_fb == LVL_OFF) begin
                    state_d = OFF;
                end
            end
            OFF: begin
                if (tmr_zero && c_fb == LVL_OFF) begin
                    if (target_q == LVL_OFF) begin
                        done_d  = 1'b1;
                        state_d = IDLE;
                    end else begin
                        step_d  = LVL_1;
                        state_d = STEP;
                    end
                end
            end
`ifdef REV_RAMP_TIMEOUT_EN
            ERR: begin
                if (err_clr) begin
                    state_d = IDLE;
                end
            end
`endif
            default: state_d = IDLE;
        endcase

        // Every way into OFF (down command, lost A) starts the same off timing.
        if (state_d == OFF && state_q != OFF) begin
            tmr_load    = 1'b1;
            tmr_val     = OFF_LD;
            cur_level_d = LVL_OFF;
        end
`ifdef REV_RAMP_TIMEOUT_EN
        if (state_d == STEP && state_q != STEP) begin
            tmr_load = 1'b1;
            tmr_val  = TMO_LD;
        end
`endif
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            step_q      <= LVL_OFF;
            target_q    <= LVL_OFF;
            cur_level_q <= LVL_OFF;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            step_q      <= step_d;
            target_q    <= target_d;
            cur_level_q <= cur_level_d;
            done_q      <= done_d;
        end
    end

    always_comb begin
        rev_a     = 1'b0;
        rev_r     = LVL_OFF;
        cmd_ready = 1'b0;
        busy      = 1'b0;
        case (state_q)
            IDLE: cmd_ready = 1'b1;
            STEP, DWELL: begin
                rev_a = 1'b1;
                rev_r = step_q;
                busy  = 1'b1;
            end
            HOLD: begin
                rev_a     = 1'b1;
                rev_r     = step_q;
                cmd_ready = 1'b1;
            end
            OFF: busy = 1'b1;
            default: ;
        endcase
    end

    assign cur_level = cur_level_q;
    assign done      = done_q;

`ifdef REV_RAMP_TIMEOUT_EN
    assign err = (state_q == ERR);
`else
    assign err = 1'b0;
    logic unused_err_clr;
    assign unused_err_clr = err_clr;
`endif

endmodule
